// File: rtl/cpu_sequencer.sv
// Fetch/execute sequencer for the 8-bit experiment CPU: PC, IR, operand register, memory read handshake, one-hot decode.
// Optional single-step mode is enabled by defining SEQ_STEP_EN.
module cpu_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter logic [3:0] HALT_OPC = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        step,
  input  logic        g,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        mem_req,
  output logic [7:0]  mem_addr,
  output logic [7:0]  pc,
  output logic [7:0]  ir,
  output logic [7:0]  opnd,
  output logic        sm,
  output logic [13:0] dec,
  output logic        halted
);

`ifdef SEQ_STEP_EN
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_OPND, S_EXEC, S_HALTED, S_PAUSE} state_t;
  logic step_q;
`else
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_OPND, S_EXEC, S_HALTED} state_t;
  logic unused_step;
  assign unused_step = step;
`endif

  localparam int D_JMP  = 9;
  localparam int D_HALT = 11;
  localparam int D_GTK  = 13;

  state_t     state;
  logic       ack_ok;
  logic [7:0] exec_pc;

  function automatic logic [13:0] decode(input logic [3:0] opc, input logic gf);
    logic [13:0] d;
    d = '0;
    if (opc == HALT_OPC) d[11] = 1'b1;
    else begin
      case (opc)
        4'h1: d[0]  = 1'b1;
        4'h2: d[1]  = 1'b1;
        4'h3: d[2]  = 1'b1;
        4'h4: d[3]  = 1'b1;
        4'h5: d[4]  = 1'b1;
        4'h6: d[5]  = 1'b1;
        4'h7: d[6]  = 1'b1;
        4'h8: d[7]  = 1'b1;
        4'h9: d[8]  = 1'b1;
        4'hA: d[9]  = 1'b1;
        4'hB: begin d[10] = 1'b1; d[13] = gf; end
        default: d[12] = 1'b1;
      endcase
    end
    return d;
  endfunction

  function automatic logic two_byte(input logic [3:0] opc);
    return (opc != HALT_OPC) && (opc == 4'h5 || opc == 4'hA || opc == 4'hB);
  endfunction

  assign ack_ok = mem_req & mem_ack;
  // g is captured as dec[13] on entry to EXEC so the strobe and the branch always agree
  assign exec_pc = (dec[D_JMP] | dec[D_GTK]) ? opnd : pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      ir       <= '0;
      opnd     <= '0;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
      sm       <= 1'b0;
      dec      <= '0;
      halted   <= 1'b0;
`ifdef SEQ_STEP_EN
      step_q   <= 1'b0;
`endif
    end else begin
`ifdef SEQ_STEP_EN
      step_q <= step;
`endif
      case (state)
        S_IDLE: if (run) begin
          state    <= S_FETCH;
          mem_req  <= 1'b1;
          mem_addr <= pc;
        end
        S_FETCH: if (ack_ok) begin
          ir <= mem_rdata;
          pc <= pc + 8'd1;
          if (two_byte(mem_rdata[7:4])) begin
            state    <= S_OPND;
            mem_addr <= pc + 8'd1;
          end else begin
            state   <= S_EXEC;
            mem_req <= 1'b0;
            sm      <= 1'b1;
            dec     <= decode(mem_rdata[7:4], g);
          end
        end
        S_OPND: if (ack_ok) begin
          opnd    <= mem_rdata;
          pc      <= pc + 8'd1;
          state   <= S_EXEC;
          mem_req <= 1'b0;
          sm      <= 1'b1;
          dec     <= decode(ir[7:4], g);
        end
        S_EXEC: begin
          sm  <= 1'b0;
          dec <= '0;
          pc  <= exec_pc;
          if (dec[D_HALT]) begin
            state  <= S_HALTED;
            halted <= 1'b1;
          end else begin
`ifdef SEQ_STEP_EN
            state <= S_PAUSE;
`else
            if (run) begin
              state    <= S_FETCH;
              mem_req  <= 1'b1;
              mem_addr <= exec_pc;
            end else state <= S_IDLE;
`endif
          end
        end
        S_HALTED: state <= S_HALTED;
`ifdef SEQ_STEP_EN
        S_PAUSE: begin
          if (!run) state <= S_IDLE;
          else if (step && !step_q) begin
            state    <= S_FETCH;
            mem_req  <= 1'b1;
            mem_addr <= pc;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with a wait-state-configurable memory model.
module tb_cpu_sequencer;
  logic        clk = 1'b0;
  logic        rst, run, step, g, mem_ack, force_ack;
  logic [7:0]  mem_rdata, mem_addr, pc, ir, opnd;
  logic        mem_req, sm, halted;
  logic [13:0] dec;
  logic [7:0]  mem [256];
  int          wait_n, wcnt;
  int          vectors = 0, miscompares = 0;
  int          cnt;

  cpu_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .g(g),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_req(mem_req),
    .mem_addr(mem_addr), .pc(pc), .ir(ir), .opnd(opnd), .sm(sm),
    .dec(dec), .halted(halted)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  assign mem_ack   = (mem_req && (wcnt == wait_n)) || force_ack;

  always_ff @(posedge clk)
    if (rst || !mem_req || mem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0;
    tick(); tick();
    rst = 1'b0; run = 1'b1;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; step = 1'b0; g = 1'b0; force_ack = 1'b0; wait_n = 0;
    clear_mem();

    // reset values
    tick(); tick();
    check("rst_pc", 16'(pc), 16'h00);
    check("rst_ir", 16'(ir), 16'h00);
    check("rst_opnd", 16'(opnd), 16'h00);
    check("rst_req", 16'(mem_req), 16'h0);
    check("rst_sm", 16'(sm), 16'h0);
    check("rst_dec", 16'(dec), 16'h0);
    check("rst_halted", 16'(halted), 16'h0);

    // ADD then HALT, zero wait states
    mem[8'h00] = 8'h61; mem[8'h01] = 8'hF0;
    rst = 1'b0; run = 1'b1;
    tick();
    check("t1_c1_req", 16'(mem_req), 16'h1);
    check("t1_c1_addr", 16'(mem_addr), 16'h00);
    tick();
    check("t1_c2_dec_add", 16'(dec), 16'h0020);
    check("t1_c2_sm", 16'(sm), 16'h1);
    check("t1_c2_ir", 16'(ir), 16'h61);
    tick();
    check("t1_c3_dec", 16'(dec), 16'h0000);
    check("t1_c3_addr", 16'(mem_addr), 16'h01);
    tick();
    check("t1_c4_dec_halt", 16'(dec), 16'h0800);
    tick();
    check("t1_halted", 16'(halted), 16'h1);
    check("t1_pc", 16'(pc), 16'h02);
    check("t1_req", 16'(mem_req), 16'h0);
    run = 1'b0; tick(); run = 1'b1; tick(); run = 1'b0; tick(); run = 1'b1; tick();
    check("t1_halted_sticky", 16'(halted), 16'h1);
    check("t1_pc_sticky", 16'(pc), 16'h02);
    check("t1_sm_sticky", 16'(sm), 16'h0);

    // MOVI with 2 wait states per access
    clear_mem();
    mem[8'h00] = 8'h54; mem[8'h01] = 8'h3C; mem[8'h02] = 8'hF0;
    wait_n = 2;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t2_fetch_addr%0d", i), 16'(mem_addr), 16'h00);
      check($sformatf("t2_fetch_req%0d", i), 16'(mem_req), 16'h1);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t2_opnd_addr%0d", i), 16'(mem_addr), 16'h01);
      check($sformatf("t2_opnd_dec%0d", i), 16'(dec), 16'h0000);
    end
    tick();
    check("t2_dec_movi", 16'(dec), 16'h0010);
    check("t2_opnd", 16'(opnd), 16'h3C);
    check("t2_pc", 16'(pc), 16'h02);
    tick();
    check("t2_dec_after", 16'(dec), 16'h0000);
    check("t2_addr_next", 16'(mem_addr), 16'h02);

    // JG taken: JMP 10, then JG 40 at 10
    clear_mem();
    mem[8'h00] = 8'hA0; mem[8'h01] = 8'h10;
    mem[8'h10] = 8'hB0; mem[8'h11] = 8'h40;
    mem[8'h12] = 8'hF0; mem[8'h40] = 8'hF0;
    wait_n = 0; g = 1'b1;
    do_reset();
    tick(); tick(); tick();
    check("t3_jmp_dec", 16'(dec), 16'h0200);
    tick();
    check("t3_pc_after_jmp", 16'(pc), 16'h10);
    check("t3_addr_after_jmp", 16'(mem_addr), 16'h10);
    tick(); tick();
    check("t3_jg_taken_dec", 16'(dec), 16'h2400);
    tick();
    check("t3_jg_taken_pc", 16'(pc), 16'h40);

    // JG not taken
    g = 1'b0;
    do_reset();
    tick(); tick(); tick(); tick(); tick(); tick();
    check("t3_jg_nt_dec", 16'(dec), 16'h0400);
    tick();
    check("t3_jg_nt_pc", 16'(pc), 16'h12);
    check("t3_jg_nt_addr", 16'(mem_addr), 16'h12);

    // PC wrap: MOVB at 00, JMP FF at 01, JMP (operand at 00 = 20) at FF
    clear_mem();
    mem[8'h00] = 8'h20; mem[8'h01] = 8'hA0; mem[8'h02] = 8'hFF;
    mem[8'hFF] = 8'hA0; mem[8'h20] = 8'hF0;
    do_reset();
    tick(); tick();
    check("t4_movb_dec", 16'(dec), 16'h0002);
    tick(); tick(); tick();
    check("t4_jmp1_dec", 16'(dec), 16'h0200);
    tick();
    check("t4_fetch_ff", 16'(mem_addr), 16'hFF);
    tick();
    check("t4_opnd_addr_wrap", 16'(mem_addr), 16'h00);
    check("t4_pc_wrap", 16'(pc), 16'h00);
    tick();
    check("t4_jmp2_dec", 16'(dec), 16'h0200);
    check("t4_opnd", 16'(opnd), 16'h20);
    tick();
    check("t4_pc_target", 16'(pc), 16'h20);

    // reset during OPND wait with a simultaneous ack
    clear_mem();
    mem[8'h00] = 8'h54; mem[8'h01] = 8'h3C;
    wait_n = 2;
    do_reset();
    tick(); tick(); tick(); tick();
    check("t5_in_opnd", 16'(mem_addr), 16'h01);
    rst = 1'b1; force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    check("t5_pc", 16'(pc), 16'h00);
    check("t5_ir", 16'(ir), 16'h00);
    check("t5_opnd", 16'(opnd), 16'h00);
    check("t5_req", 16'(mem_req), 16'h0);
    check("t5_sm", 16'(sm), 16'h0);
    check("t5_dec", 16'(dec), 16'h0000);
    check("t5_halted", 16'(halted), 16'h0);
    rst = 1'b0;

`ifdef SEQ_STEP_EN
    // held step executes only one instruction
    clear_mem();
    wait_n = 0;
    rst = 1'b1; run = 1'b0; step = 1'b1;
    tick(); tick();
    rst = 1'b0; run = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (dec[12]) cnt++;
    end
    check("t6_step_count", 16'(cnt), 16'd1);
    check("t6_step_pc", 16'(pc), 16'h01);
    check("t6_step_req", 16'(mem_req), 16'h0);
    step = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
